// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use interlock, branch flush, memory wait stall.
// Keeps a saturating count of ID-stall cycles.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [2:0]       i_id_re_en,
  input  logic [3:0]       i_id_re_code0,
  input  logic [3:0]       i_id_re_code1,
  input  logic [3:0]       i_id_re_code2,
  input  logic             i_ex_valid,
  input  logic             i_ex_rd_en,
  input  logic [3:0]       i_ex_rd_code,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  input  logic             i_cnt_clr,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_e;

  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic match;
  logic hazard;
  logic c_busy;
  logic c_brk;
  logic c_flush;
  logic c_haz;

  // r15 is the PC; writes to it resolve as branches, never as data hazards
  assign match =
    (i_id_re_en[0] && (i_id_re_code0 == i_ex_rd_code)) ||
    (i_id_re_en[1] && (i_id_re_code1 == i_ex_rd_code)) ||
    (i_id_re_en[2] && (i_id_re_code2 == i_ex_rd_code));

  assign hazard = i_id_valid && i_ex_valid && i_ex_rd_en &&
                  (i_ex_rd_code != 4'd15) && match;

  // Mutually exclusive conditions; gating with i_rst_n silences outputs in reset
  assign c_busy  = i_rst_n && i_mem_busy;
  assign c_brk   = i_rst_n && !i_mem_busy && i_branch_taken;
  assign c_flush = i_rst_n && !i_mem_busy && !i_branch_taken &&
                   (state_q == FLUSH);
  assign c_haz   = i_rst_n && !i_mem_busy && !i_branch_taken &&
                   (state_q == RUN) && hazard;

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_bubble_ex = 1'b0;
    o_flush_id  = 1'b0;
    unique case (1'b1)
      c_busy: begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_stall_ex  = 1'b1;
        o_stall_mem = 1'b1;
      end
      c_brk: begin
        o_flush_id = 1'b1;
        fcnt_d     = FLOAD;
        state_d    = (FLOAD != 3'd0) ? FLUSH : RUN;
      end
      c_flush: begin
        o_flush_id = 1'b1;
        fcnt_d     = (fcnt_q == 3'd0) ? 3'd0 : fcnt_q - 3'd1;
        state_d    = (fcnt_q <= 3'd1) ? RUN : FLUSH;
      end
      c_haz: begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (o_stall_id && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
// Control outputs are compared as {stall_if,id,ex,mem,bubble_ex,flush_id}.
module tb_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_id_valid;
  logic [2:0] i_id_re_en;
  logic [3:0] i_id_re_code0, i_id_re_code1, i_id_re_code2;
  logic       i_ex_valid, i_ex_rd_en;
  logic [3:0] i_ex_rd_code;
  logic       i_branch_taken, i_mem_busy, i_cnt_clr;
  logic       o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic       o_bubble_ex, o_flush_id;
  logic [1:0] o_state;
  logic [3:0] o_stall_cnt;
  logic [5:0] ctl;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .i_id_re_en(i_id_re_en),
    .i_id_re_code0(i_id_re_code0), .i_id_re_code1(i_id_re_code1),
    .i_id_re_code2(i_id_re_code2),
    .i_ex_valid(i_ex_valid), .i_ex_rd_en(i_ex_rd_en),
    .i_ex_rd_code(i_ex_rd_code),
    .i_branch_taken(i_branch_taken), .i_mem_busy(i_mem_busy),
    .i_cnt_clr(i_cnt_clr),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id),
    .o_stall_ex(o_stall_ex), .o_stall_mem(o_stall_mem),
    .o_bubble_ex(o_bubble_ex), .o_flush_id(o_flush_id),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt)
  );

  assign ctl = {o_stall_if, o_stall_id, o_stall_ex,
                o_stall_mem, o_bubble_ex, o_flush_id};

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_id_valid = 0; i_id_re_en = 0;
    i_id_re_code0 = 0; i_id_re_code1 = 0; i_id_re_code2 = 0;
    i_ex_valid = 0; i_ex_rd_en = 0; i_ex_rd_code = 0;
    i_branch_taken = 0; i_mem_busy = 0; i_cnt_clr = 0;
  endtask

  // EX writes r3, ID reads r3 on operand 1
  task automatic set_haz();
    i_ex_valid = 1; i_ex_rd_en = 1; i_ex_rd_code = 4'd3;
    i_id_valid = 1; i_id_re_en = 3'b010;
    i_id_re_code0 = 4'd5; i_id_re_code1 = 4'd3; i_id_re_code2 = 4'd7;
  endtask

  task automatic clr_cnt();
    i_cnt_clr = 1; tick(); i_cnt_clr = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 0; idle(); set_haz(); i_branch_taken = 1; i_mem_busy = 1;
    #3;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL reset_ctl got %b exp 000000", ctl);
    end
    n_cmp++;
    if (o_state !== 2'd0 || o_stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL reset_regs got st=%0d cnt=%0d exp 0/0", o_state, o_stall_cnt);
    end
    tick();
    n_cmp++;
    if (o_state !== 2'd0 || o_stall_cnt !== 4'd0 || ctl !== 6'b0) begin
      n_err++;
      $display("FAIL reset_edge got st=%0d cnt=%0d ctl=%b exp 0/0/0",
               o_state, o_stall_cnt, ctl);
    end
    idle();
    #2 i_rst_n = 1;
    tick();
  endtask

  task automatic test_hazard();
    clr_cnt();
    set_haz(); #1;
    n_cmp++;
    if (ctl !== 6'b110010) begin
      n_err++; $display("FAIL haz_op1 got %b exp 110010", ctl);
    end
    tick();
    i_ex_valid = 0; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL haz_bubble got %b exp 000000", ctl);
    end
    n_cmp++;
    if (o_stall_cnt !== 4'd1) begin
      n_err++; $display("FAIL haz_cnt got %0d exp 1", o_stall_cnt);
    end
    i_ex_valid = 1; i_ex_rd_code = 4'd9;
    i_id_re_en = 3'b100; i_id_re_code2 = 4'd9; #1;
    n_cmp++;
    if (ctl !== 6'b110010) begin
      n_err++; $display("FAIL haz_op2 got %b exp 110010", ctl);
    end
    i_id_re_en = 3'b010; i_id_re_code0 = 4'd9; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL haz_re_en_off got %b exp 000000", ctl);
    end
    i_id_re_en = 3'b001; i_ex_rd_en = 0; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL haz_no_rd_en got %b exp 000000", ctl);
    end
    i_ex_rd_en = 1; i_id_valid = 0; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL haz_id_invalid got %b exp 000000", ctl);
    end
    idle(); tick();
  endtask

  task automatic test_branch();
    i_ex_valid = 1; i_ex_rd_en = 1; i_ex_rd_code = 4'd15;
    i_id_valid = 1; i_id_re_en = 3'b001; i_id_re_code0 = 4'd15; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL r15_no_haz got %b exp 000000", ctl);
    end
    i_branch_taken = 1; #1;
    n_cmp++;
    if (ctl !== 6'b000001 || o_state !== 2'd0) begin
      n_err++;
      $display("FAIL br_cyc0 got ctl=%b st=%0d exp 000001/0", ctl, o_state);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (ctl !== 6'b000001 || o_state !== 2'd1) begin
      n_err++;
      $display("FAIL br_cyc1 got ctl=%b st=%0d exp 000001/1", ctl, o_state);
    end
    tick();
    n_cmp++;
    if (ctl !== 6'b000000 || o_state !== 2'd0) begin
      n_err++;
      $display("FAIL br_done got ctl=%b st=%0d exp 000000/0", ctl, o_state);
    end
  endtask

  task automatic test_flush_wait();
    clr_cnt();
    i_branch_taken = 1; tick(); i_branch_taken = 0;
    i_mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== 6'b111100 || o_state !== 2'd1) begin
        n_err++;
        $display("FAIL busy_in_flush[%0d] got ctl=%b st=%0d exp 111100/1",
                 i, ctl, o_state);
      end
      tick();
    end
    i_mem_busy = 0; #1;
    n_cmp++;
    if (ctl !== 6'b000001 || o_state !== 2'd1 || o_stall_cnt !== 4'd3) begin
      n_err++;
      $display("FAIL busy_release got ctl=%b st=%0d cnt=%0d exp 000001/1/3",
               ctl, o_state, o_stall_cnt);
    end
    tick();
    n_cmp++;
    if (ctl !== 6'b000000 || o_state !== 2'd0) begin
      n_err++;
      $display("FAIL busy_run got ctl=%b st=%0d exp 000000/0", ctl, o_state);
    end
    i_branch_taken = 1; tick(); i_branch_taken = 0;
    set_haz(); #1;
    n_cmp++;
    if (ctl !== 6'b000001) begin
      n_err++; $display("FAIL haz_in_flush got %b exp 000001", ctl);
    end
    i_branch_taken = 1; #1;
    n_cmp++;
    if (ctl !== 6'b000001) begin
      n_err++; $display("FAIL br_in_flush got %b exp 000001", ctl);
    end
    tick(); i_branch_taken = 0; #1;
    n_cmp++;
    if (o_state !== 2'd1 || ctl !== 6'b000001) begin
      n_err++;
      $display("FAIL reload got st=%0d ctl=%b exp 1/000001", o_state, ctl);
    end
    tick();
    n_cmp++;
    if (o_state !== 2'd0 || ctl !== 6'b110010) begin
      n_err++;
      $display("FAIL reload_end got st=%0d ctl=%b exp 0/110010", o_state, ctl);
    end
    idle();
  endtask

  task automatic test_priority();
    clr_cnt();
    set_haz(); i_branch_taken = 1; #1;
    n_cmp++;
    if (ctl !== 6'b000001) begin
      n_err++; $display("FAIL haz_and_br got %b exp 000001", ctl);
    end
    tick(); i_branch_taken = 0;
    tick();
    i_mem_busy = 1; #1;
    n_cmp++;
    if (ctl !== 6'b111100) begin
      n_err++; $display("FAIL haz_and_busy got %b exp 111100", ctl);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (o_stall_cnt !== 4'd1) begin
      n_err++; $display("FAIL prio_cnt got %0d exp 1", o_stall_cnt);
    end
  endtask

  task automatic test_saturation();
    clr_cnt();
    set_haz();
    for (int i = 0; i < 14; i++) tick();
    n_cmp++;
    if (o_stall_cnt !== 4'd14) begin
      n_err++; $display("FAIL cnt_14 got %0d exp 14", o_stall_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (o_stall_cnt !== 4'd15) begin
      n_err++; $display("FAIL cnt_sat got %0d exp 15", o_stall_cnt);
    end
    i_cnt_clr = 1; tick(); i_cnt_clr = 0;
    n_cmp++;
    if (o_stall_cnt !== 4'd0) begin
      n_err++; $display("FAIL cnt_clr got %0d exp 0", o_stall_cnt);
    end
    tick();
    n_cmp++;
    if (o_stall_cnt !== 4'd1) begin
      n_err++; $display("FAIL cnt_after_clr got %0d exp 1", o_stall_cnt);
    end
    idle();
  endtask

  task automatic test_async_reset();
    i_branch_taken = 1; tick(); i_branch_taken = 0;
    #2 i_rst_n = 0;
    #1;
    n_cmp++;
    if (o_state !== 2'd0 || ctl !== 6'b0 || o_stall_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL arst got st=%0d ctl=%b cnt=%0d exp 0/000000/0",
               o_state, ctl, o_stall_cnt);
    end
    i_branch_taken = 1; i_mem_busy = 1; #1;
    n_cmp++;
    if (ctl !== 6'b000000) begin
      n_err++; $display("FAIL arst_inputs got %b exp 000000", ctl);
    end
    tick(); idle();
    #3 i_rst_n = 1;
    set_haz();
    tick();
    n_cmp++;
    if (o_stall_cnt !== 4'd1 || o_state !== 2'd0) begin
      n_err++;
      $display("FAIL post_rst got cnt=%0d st=%0d exp 1/0", o_stall_cnt, o_state);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_branch();
    test_flush_wait();
    test_priority();
    test_saturation();
    test_async_reset();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 FLUSH_CYCLES, 2, number of cycles o_flush_id stays asserted per taken branch (legal range 1..7).
REQ-002 CNT_W, 16, width of the stall statistics counter.
REQ-003 i_clk  in  1  single pipeline clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_id_valid  in  1  ID stage holds a valid instruction.
REQ-006 i_id_re_en  in  3  per-operand read enable for ID source registers 0..2.
REQ-007 i_id_re_code0, i_id_re_code1, i_id_re_code2  in  4 each  ID source register codes.
REQ-008 i_ex_valid  in  1  EX stage holds a valid instruction.
REQ-009 i_ex_rd_en  in  1  EX instruction writes a register.
REQ-010 i_ex_rd_code  in  4  EX destination register code.
REQ-011 i_branch_taken  in  1  EX resolves a taken branch or a write to r15.
REQ-012 i_mem_busy  in  1  data memory wait state; MEM cannot complete this cycle.
REQ-013 i_cnt_clr  in  1  synchronous clear of the stall counter.
REQ-014 o_stall_if, o_stall_id  out  1 each  hold the IF / ID pipeline registers.
REQ-015 o_stall_ex, o_stall_mem  out  1 each  hold the EX / MEM pipeline registers.
REQ-016 o_bubble_ex  out  1  load a NOP into EX instead of the ID instruction.
REQ-017 o_flush_id  out  1  invalidate the IF/ID contents.
REQ-018 o_state  out  2  registered state: 0 = RUN, 1 = FLUSH.
REQ-019 o_stall_cnt  out  CNT_W  saturating count of ID-stall cycles.

Function
REQ-020 The register file forwards only WB -> EX, so an ID source that matches the EX destination SHALL cause a one-cycle interlock.
REQ-021 A hazard SHALL exist when all of the following hold: i_id_valid, i_ex_valid, i_ex_rd_en, i_ex_rd_code != 15, and at least one i_id_re_en[k] with i_id_re_code_k == i_ex_rd_code.
REQ-022 Outputs SHALL be combinational from the registered state and the current inputs, with priority mem_busy > branch > hazard.
REQ-023 When i_mem_busy = 1, the block SHALL assert all four stall outputs and SHALL hold o_bubble_ex = 0, o_flush_id = 0; state and the flush counter SHALL freeze.
REQ-024 When a branch is taken (i_branch_taken = 1, i_mem_busy = 0), the block SHALL assert o_flush_id in the same cycle and hold all stalls and o_bubble_ex at 0.
REQ-025 On the next edge after a taken branch, the block SHALL load the flush counter with FLUSH_CYCLES-1 and enter FLUSH if that value is nonzero, else stay in RUN.
REQ-026 In FLUSH with i_mem_busy = 0, the block SHALL assert o_flush_id and decrement the counter each cycle, and return to RUN in the cycle after the counter reaches 0 (total flush = FLUSH_CYCLES cycles).
REQ-027 A taken branch while in FLUSH SHALL reload the counter per REQ-025.
REQ-028 Hazards SHALL be ignored in FLUSH.
REQ-029 When a hazard occurs in RUN with no mem_busy or branch, the block SHALL assert o_stall_if, o_stall_id and o_bubble_ex, and hold o_stall_ex = o_stall_mem = 0.
REQ-030 A hazard bubble SHALL last exactly one cycle, because the producer then leaves EX; no state is entered.
REQ-031 o_stall_cnt SHALL increment by 1 on each edge where o_stall_id = 1.
REQ-032 o_stall_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 i_cnt_clr SHALL zero o_stall_cnt and SHALL take priority over the increment.
REQ-034 When no condition applies, all control outputs SHALL be 0.

Reset
REQ-035 Asserting i_rst_n = 0 SHALL, immediately and at any point including mid-FLUSH or mid-wait, set state = RUN, flush counter = 0 and o_stall_cnt = 0.
REQ-036 While in reset, all combinational outputs SHALL be 0 regardless of inputs.
REQ-037 After release, the first edge SHALL evaluate inputs normally.

Verification
REQ-038 EX writes r3, ID reads r3 on operand 1 -> stall_if/id = 1, bubble_ex = 1 for one cycle; next cycle with EX = bubble -> all 0; stall_cnt = 1.
REQ-039 EX writes r15, ID reads r15 -> no hazard; i_branch_taken = 1 -> flush_id high for 2 cycles (FLUSH_CYCLES = 2), o_state = 1 for exactly one cycle.
REQ-040 i_mem_busy high 3 cycles during FLUSH with counter = 1 -> all stalls high, counter frozen; after release flush_id for 1 more cycle, then RUN.
REQ-041 Hazard together with branch_taken -> flush_id = 1, bubble_ex = 0; hazard together with mem_busy -> all stalls high, bubble_ex = 0.
REQ-042 CNT_W = 4, 20 stall cycles -> cnt = 15; i_cnt_clr on a stall cycle -> cnt = 0.
REQ-043 i_rst_n pulsed low mid-FLUSH -> o_state = 0, flush_id = 0, cnt = 0 asynchronously.
